// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//   Stall/flush controller for the 5-stage RISC-V pipeline. Covers the hazards
//   operand forwarding cannot hide: load-use (one-cycle stall plus an ID/EX
//   bubble), taken branch (flush of IF/ID and ID/EX), and data-memory wait
//   (full freeze). A RUN/WAIT/HALT FSM halts the core when memory stays busy
//   for MEM_TIMEOUT consecutive cycles. Two saturating counters record stall
//   cycles and branch flushes.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   IFIDrs1/rs2, IFIDuseRs1/Rs2  source registers of the ID instruction
//   IDEXrd, IDEXmemRead          destination / load flag of the EX instruction
//   branchTaken                  EX resolved a taken branch or jump
//   EXMEMmemAccess, dmemReady    MEM-stage access and memory completion
//   pcWrite..memwbWrite          pipeline register write enables
//   ifidFlush, idexBubble        NOP insertion into IF/ID and ID/EX
//   halted                       registered halt flag (sticky until reset)
//   stallCycles, flushCount      saturating performance counters
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       IFIDrs1,
  input  logic [4:0]       IFIDrs2,
  input  logic             IFIDuseRs1,
  input  logic             IFIDuseRs2,
  input  logic [4:0]       IDEXrd,
  input  logic             IDEXmemRead,
  input  logic             branchTaken,
  input  logic             EXMEMmemAccess,
  input  logic             dmemReady,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexWrite,
  output logic             exmemWrite,
  output logic             memwbWrite,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic             halted,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WCNT_W-1:0]   r_waitCnt;
  logic [WCNT_W-1:0]   w_waitCnt_nxt;
  logic                r_halted;
  logic                w_halted_nxt;
  logic [CNT_W-1:0]    r_stallCycles;
  logic [CNT_W-1:0]    r_flushCount;

  logic                w_memBusy;
  logic                w_loadUse;
  logic                w_flushFire;
  logic                w_stallCount;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_memBusy = EXMEMmemAccess & ~dmemReady;

  // rd == x0 never creates a dependency; unused source fields are ignored.
  assign w_loadUse = IDEXmemRead & (IDEXrd != 5'd0) &
                     ((IFIDuseRs1 & (IDEXrd == IFIDrs1)) |
                      (IFIDuseRs2 & (IDEXrd == IFIDrs2)));

  // Output priority: HALT > memory freeze > branch flush > load-use > run.
  // During a freeze a pending branch stays in EX and is flushed on release.
  always_comb begin
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    idexWrite   = 1'b1;
    exmemWrite  = 1'b1;
    memwbWrite  = 1'b1;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;
    w_flushFire = 1'b0;
    if (r_state == S_HALT || w_memBusy) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexWrite  = 1'b0;
      exmemWrite = 1'b0;
      memwbWrite = 1'b0;
    end else if (branchTaken) begin
      ifidFlush   = 1'b1;
      idexBubble  = 1'b1;
      w_flushFire = 1'b1;
    end else if (w_loadUse) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end
  end

  assign w_stallCount = ~pcWrite & (r_state != S_HALT);

  // waitCnt counts consecutive busy cycles; the busy cycle seen while
  // waitCnt == MEM_TIMEOUT-1 is the MEM_TIMEOUT-th one and halts the core.
  always_comb begin
    w_state_nxt   = r_state;
    w_waitCnt_nxt = r_waitCnt;
    w_halted_nxt  = r_halted;
    unique case (r_state)
      S_RUN: begin
        if (w_memBusy) begin
          w_state_nxt   = S_WAIT;
          w_waitCnt_nxt = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!w_memBusy) begin
          w_state_nxt   = S_RUN;
          w_waitCnt_nxt = '0;
        end else if (r_waitCnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
          w_state_nxt  = S_HALT;
          w_halted_nxt = 1'b1;
        end else begin
          w_waitCnt_nxt = r_waitCnt + WCNT_W'(1);
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt   = S_RUN;
        w_waitCnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RUN;
      r_waitCnt     <= '0;
      r_halted      <= 1'b0;
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_waitCnt <= w_waitCnt_nxt;
      r_halted  <= w_halted_nxt;
      if (w_stallCount) r_stallCycles <= sat_inc(r_stallCycles);
      if (w_flushFire)  r_flushCount  <= sat_inc(r_flushCount);
    end
  end

  assign halted      = r_halted;
  assign stallCycles = r_stallCycles;
  assign flushCount  = r_flushCount;

endmodule
